reaction_responder: RTL and testbench
=====================================

Name: reaction_responder

Overview:
- Automatic "subject" for the reaction-timer lab. It is the responder end of the stimulus/response interface.
- Once armed, it watches the stimulus LED line. After the LED turns on, it waits a programmed number of milliseconds, then drives an active-low pushbutton line low for a fixed hold time.
- It also reports the measured stimulus-to-press interval as a 4-digit BCD value.
- Used in the board-level bench and as an on-board self-test source in place of the human pressing the reaction key.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- TICK_HZ, 1000, response-timing tick rate (1 ms). DIV = CLK_HZ/TICK_HZ clocks per tick.
- HOLD_TICKS, 20, number of ticks key_n is held low per press. Legal range is 1..255.

Ports:
- CLOCK_50  input  1  system clock; all logic on rising edge.
- resetn  input  1  asynchronous active-low reset.
- arm  input  1  single-cycle request to start one response cycle; sampled only in IDLE.
- stim  input  1  stimulus LED line (active-high), asynchronous to CLOCK_50.
- delay_bcd  input  16  response delay, 4 BCD digits, in ticks (0000..9999); captured on arm.
- key_n  output  1  emulated pushbutton, active-low.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a press completes.
- aborted  output  1  one-cycle pulse when stim drops before the press starts.
- elapsed_bcd  output  16  BCD ticks from stim rising edge to press start; held until the next stim edge.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE, key_n=1, busy=0, done=0, aborted=0, elapsed_bcd=0000.
  - Synchronizer, prescaler and hold counter cleared.
  - Reset mid-press releases key_n immediately, without waiting for a clock edge.
- stim input path:
  - 2-flop synchronizer, then a registered copy for edge detection.
  - A rising edge is recognised 3 clocks after stim rises; a falling edge likewise.
- Delay capture: on arm in IDLE, delay_bcd is registered. Any digit >9 is clamped to 9.
- State machine:
  - IDLE: key_n=1. On arm=1, go to ARMED. arm in any other state is ignored.
  - ARMED: wait for the stim rising edge.
    - If stim is already high when armed, wait for it to go low and rise again; a level is not an edge.
    - On the edge: clear elapsed_bcd to 0000, clear the prescaler, go to COUNT.
  - COUNT:
    - The prescaler counts 0..DIV-1. The tick fires on the clock where the prescaler equals DIV-1, so the first tick is DIV clocks after entering COUNT.
    - Each tick increments elapsed_bcd with decimal carry per digit. It saturates at 9999 and never wraps.
    - Each clock, compare elapsed_bcd with the captured delay. When equal, go to PRESS.
    - A delay of 0000 therefore gives PRESS on the clock after entering COUNT.
    - Synchronized stim falling edge in COUNT: pulse aborted, go to IDLE. If the compare matches on the same clock, the abort wins.
  - PRESS:
    - key_n=0. The hold counter counts ticks, using the prescaler restarted at PRESS entry.
    - After HOLD_TICKS ticks, go to DONE. stim changes are ignored here.
    - elapsed_bcd is frozen on PRESS entry.
  - DONE: key_n=1, done=1 for exactly this cycle, then IDLE.
- Outputs:
  - All outputs are registered.
  - key_n glitch-free; it changes only on a state change.
  - busy = (state != IDLE).

Test Plan (CLK_HZ=1000, TICK_HZ=100 → DIV=10, HOLD_TICKS=3):
- Nominal:
  - Stimulus: reset, arm with delay_bcd=0x0005, raise stim at clock T.
  - Required: key_n falls at T+3+1+50 (±1); stays low 30 clocks; done pulses once; elapsed_bcd=0x0005; busy drops the clock after done.
- Zero delay:
  - Stimulus: arm with delay_bcd=0x0000, raise stim.
  - Required: key_n low 5 clocks after the stim rise; elapsed_bcd=0x0000.
- BCD carry and clamp:
  - Stimulus: arm with delay_bcd=0x001A.
  - Required: delay clamps to 0x0019; elapsed_bcd passes 0009→0010 (no 000A); press at 19 ticks.
- Abort:
  - Stimulus: arm with delay 0x0010, stim high 4 ticks then low.
  - Required: aborted pulses once; key_n stays 1; no done; state returns to IDLE; elapsed_bcd=0x0004.
- Stim already high:
  - Stimulus: stim=1 before arm.
  - Required: no press until stim goes 0 then 1; timing then as in the nominal case.
- Async reset mid-press:
  - Stimulus: assert resetn=0 while key_n=0, between clock edges.
  - Required: key_n=1 and busy=0 immediately; elapsed_bcd=0000; arm ignored while resetn=0.

Source files
------------

// File: rtl/reaction_responder.sv
`default_nettype none
// ============================================================================
// Module      : reaction_responder
// Description : Automatic reaction-timer subject: after the stimulus LED rises,
//               waits a BCD-programmed tick count, then presses key_n.
// Revision    : 1.0 - initial release
// ============================================================================
module reaction_responder #(
    parameter int CLK_HZ     = 50000000,
    parameter int TICK_HZ    = 1000,
    parameter int HOLD_TICKS = 20
) (
    input  logic        CLOCK_50,
    input  logic        resetn,
    input  logic        arm,
    input  logic        stim,
    input  logic [15:0] delay_bcd,
    output logic        key_n,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [15:0] elapsed_bcd
);

    localparam int C_DIV = CLK_HZ / TICK_HZ;
    localparam int C_PW  = (C_DIV > 1) ? $clog2(C_DIV) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARMED = 3'd1,
        S_COUNT = 3'd2,
        S_PRESS = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_sync1;
    logic              r_sync2;
    logic              r_stimD;
    logic [C_PW-1:0]   r_pre;
    logic [7:0]        r_hold;
    logic [15:0]       r_delay;
    logic              w_rise;
    logic              w_fall;
    logic              w_tick;
    logic              w_match;
    logic              w_holdEnd;

    function automatic logic [15:0] clampBcd(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = (v[i*4 +: 4] > 4'd9) ? 4'd9 : v[i*4 +: 4];
        end
        return r;
    endfunction

    // Decimal increment that sticks at 9999 instead of wrapping.
    function automatic logic [15:0] incBcd(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        if (v != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (v[i*4 +: 4] >= 4'd9) begin
                        r[i*4 +: 4] = 4'd0;
                    end else begin
                        r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    assign w_rise    = r_sync2 & ~r_stimD;
    assign w_fall    = ~r_sync2 & r_stimD;
    assign w_tick    = (r_pre == C_PW'(C_DIV - 1));
    assign w_match   = (elapsed_bcd == r_delay);
    assign w_holdEnd = w_tick && (r_hold == 8'(HOLD_TICKS - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (arm) w_next = S_ARMED;
            S_ARMED: if (w_rise) w_next = S_COUNT;
            S_COUNT: begin
                if (w_fall) begin
                    w_next = S_IDLE;
                end else if (w_match) begin
                    w_next = S_PRESS;
                end
            end
            S_PRESS: if (w_holdEnd) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_stimD <= 1'b0;
        end else begin
            r_state <= w_next;
            r_sync1 <= stim;
            r_sync2 <= r_sync1;
            r_stimD <= r_sync2;
        end
    end

    // Prescaler and hold counter restart on every state change.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_pre  <= '0;
            r_hold <= 8'd0;
        end else if (w_next != r_state) begin
            r_pre  <= '0;
            r_hold <= 8'd0;
        end else if (r_state == S_COUNT || r_state == S_PRESS) begin
            r_pre <= w_tick ? '0 : r_pre + 1'b1;
            if (r_state == S_PRESS && w_tick) begin
                r_hold <= r_hold + 8'd1;
            end
        end else begin
            r_pre <= '0;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_delay     <= 16'h0000;
            elapsed_bcd <= 16'h0000;
        end else begin
            if (r_state == S_IDLE && arm) begin
                r_delay <= clampBcd(delay_bcd);
            end
            if (r_state == S_ARMED && w_rise) begin
                elapsed_bcd <= 16'h0000;
            end else if (r_state == S_COUNT && w_tick && !w_match) begin
                elapsed_bcd <= incBcd(elapsed_bcd);
            end
        end
    end

    // Outputs decode the next state so they are registered yet state-aligned.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            key_n   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            aborted <= 1'b0;
        end else begin
            key_n   <= (w_next != S_PRESS);
            busy    <= (w_next != S_IDLE);
            done    <= (w_next == S_DONE);
            aborted <= (r_state == S_COUNT) && w_fall;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_reaction_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_reaction_responder
// Description : Directed self-checking bench for reaction_responder (DIV=10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reaction_responder;

    logic        CLOCK_50 = 1'b0;
    logic        resetn   = 1'b0;
    logic        arm      = 1'b0;
    logic        stim     = 1'b0;
    logic [15:0] delay_bcd = 16'h0000;
    logic        key_n;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [15:0] elapsed_bcd;

    int checks   = 0;
    int errors   = 0;
    int doneCnt  = 0;
    int abortCnt = 0;

    reaction_responder #(
        .CLK_HZ     (1000),
        .TICK_HZ    (100),
        .HOLD_TICKS (3)
    ) dut (
        .CLOCK_50    (CLOCK_50),
        .resetn      (resetn),
        .arm         (arm),
        .stim        (stim),
        .delay_bcd   (delay_bcd),
        .key_n       (key_n),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .elapsed_bcd (elapsed_bcd)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    always @(negedge CLOCK_50) begin
        if (done)    doneCnt++;
        if (aborted) abortCnt++;
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic armWith(input logic [15:0] d);
        delay_bcd = d;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) tick();
        checks++; if (key_n !== 1'b1) begin errors++; $display("FAIL reset_key_n got %b want 1", key_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (aborted !== 1'b0) begin errors++; $display("FAIL reset_aborted got %b want 0", aborted); end
        checks++; if (elapsed_bcd !== 16'h0000) begin errors++; $display("FAIL reset_elapsed got %h want 0000", elapsed_bcd); end
        resetn = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_nominal();
        int n;
        int low;
        int d0;
        d0 = doneCnt;
        armWith(16'h0005);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_armed got %b want 1", busy); end
        stim = 1'b1;
        n = 0;
        while (key_n !== 1'b0 && n < 400) begin tick(); n++; end
        checks++; if (n < 53 || n > 55) begin errors++; $display("FAIL nom_press_time got %0d want 53..55", n); end
        low = 0;
        while (key_n === 1'b0 && low < 100) begin tick(); low++; end
        checks++; if (low !== 30) begin errors++; $display("FAIL nom_hold_len got %0d want 30", low); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL nom_done_pulse got %b want 1", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL nom_busy_in_done got %b want 1", busy); end
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL nom_after_done got done=%b busy=%b want 0 0", done, busy); end
        checks++; if (elapsed_bcd !== 16'h0005) begin errors++; $display("FAIL nom_elapsed got %h want 0005", elapsed_bcd); end
        stim = 1'b0;
        repeat (5) tick();
        checks++; if (doneCnt - d0 !== 1) begin errors++; $display("FAIL nom_done_count got %0d want 1", doneCnt - d0); end
    endtask

    task automatic test_zero_delay();
        int n;
        armWith(16'h0000);
        stim = 1'b1;
        n = 0;
        while (key_n !== 1'b0 && n < 100) begin tick(); n++; end
        checks++; if (n < 4 || n > 5) begin errors++; $display("FAIL zero_press_time got %0d want 4..5", n); end
        checks++; if (elapsed_bcd !== 16'h0000) begin errors++; $display("FAIL zero_elapsed got %h want 0000", elapsed_bcd); end
        n = 0;
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end
        stim = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_carry_clamp();
        int n;
        logic [15:0] prev;
        logic badDigit;
        logic sawCarry;
        armWith(16'h001A);
        stim = 1'b1;
        n = 0;
        prev = 16'hFFFF;
        badDigit = 1'b0;
        sawCarry = 1'b0;
        while (key_n !== 1'b0 && n < 400) begin
            tick(); n++;
            if (elapsed_bcd[3:0] > 4'd9 || elapsed_bcd[7:4] > 4'd9) badDigit = 1'b1;
            if (prev == 16'h0009 && elapsed_bcd != 16'h0009) sawCarry = (elapsed_bcd == 16'h0010);
            prev = elapsed_bcd;
        end
        checks++; if (badDigit !== 1'b0) begin errors++; $display("FAIL carry_digit got non-decimal want decimal"); end
        checks++; if (sawCarry !== 1'b1) begin errors++; $display("FAIL carry_0009_to_0010 got %b want 1", sawCarry); end
        checks++; if (n < 193 || n > 195) begin errors++; $display("FAIL clamp_press_time got %0d want 193..195", n); end
        checks++; if (elapsed_bcd !== 16'h0019) begin errors++; $display("FAIL clamp_elapsed got %h want 0019", elapsed_bcd); end
        n = 0;
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end
        stim = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_abort();
        int a0;
        int d0;
        logic pressed;
        a0 = abortCnt;
        d0 = doneCnt;
        pressed = 1'b0;
        armWith(16'h0010);
        stim = 1'b1;
        repeat (45) begin tick(); if (key_n !== 1'b1) pressed = 1'b1; end
        stim = 1'b0;
        repeat (10) begin tick(); if (key_n !== 1'b1) pressed = 1'b1; end
        checks++; if (abortCnt - a0 !== 1) begin errors++; $display("FAIL abort_pulses got %0d want 1", abortCnt - a0); end
        checks++; if (doneCnt - d0 !== 0) begin errors++; $display("FAIL abort_done got %0d want 0", doneCnt - d0); end
        checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL abort_key_n got pressed want idle"); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (elapsed_bcd !== 16'h0004) begin errors++; $display("FAIL abort_elapsed got %h want 0004", elapsed_bcd); end
    endtask

    task automatic test_stim_high();
        int n;
        logic pressed;
        pressed = 1'b0;
        stim = 1'b1;
        repeat (5) tick();
        armWith(16'h0005);
        repeat (80) begin tick(); if (key_n !== 1'b1) pressed = 1'b1; end
        checks++; if (pressed !== 1'b0) begin errors++; $display("FAIL high_level_press got pressed want none"); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL high_still_armed got %b want 1", busy); end
        stim = 1'b0;
        repeat (5) tick();
        stim = 1'b1;
        n = 0;
        while (key_n !== 1'b0 && n < 400) begin tick(); n++; end
        checks++; if (n < 53 || n > 55) begin errors++; $display("FAIL high_press_time got %0d want 53..55", n); end
        n = 0;
        while (busy !== 1'b0 && n < 100) begin tick(); n++; end
        checks++; if (elapsed_bcd !== 16'h0005) begin errors++; $display("FAIL high_elapsed got %h want 0005", elapsed_bcd); end
        stim = 1'b0;
        repeat (5) tick();
    endtask

    task automatic test_async_reset();
        int n;
        armWith(16'h0002);
        stim = 1'b1;
        n = 0;
        while (key_n !== 1'b0 && n < 100) begin tick(); n++; end
        checks++; if (key_n !== 1'b0) begin errors++; $display("FAIL arst_precondition key_n got %b want 0", key_n); end
        repeat (3) tick();
        #2;
        resetn = 1'b0;
        arm = 1'b1;
        #1;
        checks++; if (key_n !== 1'b1) begin errors++; $display("FAIL arst_key_n got %b want 1", key_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        checks++; if (elapsed_bcd !== 16'h0000) begin errors++; $display("FAIL arst_elapsed got %h want 0000", elapsed_bcd); end
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_arm_ignored got busy=%b want 0", busy); end
        arm = 1'b0;
        stim = 1'b0;
        resetn = 1'b1;
        repeat (3) tick();
        checks++; if (busy !== 1'b0 || key_n !== 1'b1) begin errors++; $display("FAIL arst_after_release got busy=%b key_n=%b want 0 1", busy, key_n); end
    endtask

    initial begin
        tick();
        test_reset();
        test_nominal();
        test_zero_delay();
        test_carry_clamp();
        test_abort();
        test_stim_high();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
